// File: rtl/vm_pkg.sv
// Shared item codes, coin unit, sequencer states and the audit saturating
// increment for the vending back-end sequencer.
package vm_pkg;

    localparam logic [1:0] ITEM_NONE  = 2'b00;
    localparam logic [1:0] ITEM_COLA  = 2'b01;
    localparam logic [1:0] ITEM_PEPSI = 2'b10;

    localparam int unsigned COIN_UNIT = 5;
    localparam int unsigned AUDIT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        DISP,
        EJECT,
        WAIT,
        DONE,
        FAULT
    } state_t;

    function automatic logic [AUDIT_W-1:0] sat_inc(input logic [AUDIT_W-1:0] v);
        return (v == {AUDIT_W{1'b1}}) ? v : v + AUDIT_W'(1);
    endfunction

endpackage

// File: rtl/vm_timer.sv
// Loadable down-counter with an expire flag; shared by the solenoid pulse
// and the coin-drop deadline, which never run at the same time.
module vm_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire_c
);

    logic [W-1:0] count;

    // Load wins over decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire_c = (count == '0);

endmodule

// File: rtl/vm_dispense_seq.sv
// Vend back-end sequencer: solenoid timing, coin-by-coin change ejection with
// drop timeout, and per-item inventory. Define VM_AUDIT_EN for sales/coin counters.
module vm_dispense_seq
    import vm_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned COIN_TO   = 16,
    parameter int unsigned INV_W     = 4,
    parameter int unsigned INV_INIT  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_item,
    input  logic [1:0] req_change,
    input  logic       req_refund,
    output logic       sol_cola,
    output logic       sol_pepsi,
    output logic       hopper_pulse,
    input  logic       hopper_drop,
    input  logic       restock,
    input  logic       fault_clr,
    output logic [1:0] sold_out,
    output logic       busy,
    output logic       done,
    output logic       vend_ok,
    output logic       fault
`ifdef VM_AUDIT_EN
    ,
    output logic [AUDIT_W-1:0] sales_cola,
    output logic [AUDIT_W-1:0] sales_pepsi,
    output logic [AUDIT_W-1:0] coins_paid
`endif
);

    localparam int unsigned TMR_MAX = (PULSE_CYC > COIN_TO) ? PULSE_CYC : COIN_TO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state_q, state_d;
    logic [1:0]         item_q, item_d;
    logic [1:0]         coins_q, coins_d;
    logic               disp_q, disp_d;
    logic [INV_W-1:0]   inv_cola_q, inv_cola_d;
    logic [INV_W-1:0]   inv_pepsi_q, inv_pepsi_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_dec;
    logic               tmr_expire_c;

    logic               req_ready_d, busy_d, sol_cola_d, sol_pepsi_d;
    logic               hopper_pulse_d, done_d, vend_ok_d, fault_d;

    vm_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .expire_c (tmr_expire_c)
    );

    assign sold_out = {inv_pepsi_q == '0, inv_cola_q == '0};

    // State, transaction context, inventory and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            item_q       <= ITEM_NONE;
            coins_q      <= '0;
            disp_q       <= 1'b0;
            inv_cola_q   <= INV_W'(INV_INIT);
            inv_pepsi_q  <= INV_W'(INV_INIT);
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            sol_cola     <= 1'b0;
            sol_pepsi    <= 1'b0;
            hopper_pulse <= 1'b0;
            done         <= 1'b0;
            vend_ok      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            item_q       <= item_d;
            coins_q      <= coins_d;
            disp_q       <= disp_d;
            inv_cola_q   <= inv_cola_d;
            inv_pepsi_q  <= inv_pepsi_d;
            req_ready    <= req_ready_d;
            busy         <= busy_d;
            sol_cola     <= sol_cola_d;
            sol_pepsi    <= sol_pepsi_d;
            hopper_pulse <= hopper_pulse_d;
            done         <= done_d;
            vend_ok      <= vend_ok_d;
            fault        <= fault_d;
        end
    end

    // Next-state logic. The coin deadline is loaded on entry to EJECT so it
    // counts from the pulse cycle itself.
    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        coins_d     = coins_q;
        disp_d      = disp_q;
        inv_cola_d  = inv_cola_q;
        inv_pepsi_d = inv_pepsi_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (restock) begin
                    inv_cola_d  = INV_W'(INV_INIT);
                    inv_pepsi_d = INV_W'(INV_INIT);
                end
                if (req_valid && req_ready) begin
                    item_d  = req_item;
                    coins_d = req_change;
                    // Sold-out decision uses the registered (pre-restock) counts.
                    disp_d  = !req_refund &&
                              (((req_item == ITEM_COLA)  && !sold_out[0]) ||
                               ((req_item == ITEM_PEPSI) && !sold_out[1]));
                    if (disp_d) begin
                        if ((req_item == ITEM_COLA) && (inv_cola_d != '0)) begin
                            inv_cola_d = inv_cola_d - INV_W'(1);
                        end
                        if ((req_item == ITEM_PEPSI) && (inv_pepsi_d != '0)) begin
                            inv_pepsi_d = inv_pepsi_d - INV_W'(1);
                        end
                        state_d  = DISP;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(PULSE_CYC - 1);
                    end else if (req_change != 2'd0) begin
                        state_d  = EJECT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(COIN_TO - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DISP: begin
                if (tmr_expire_c) begin
                    if (coins_q != 2'd0) begin
                        state_d  = EJECT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(COIN_TO - 1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            EJECT: begin
                state_d = WAIT;
                tmr_dec = 1'b1;
            end
            WAIT: begin
                if (hopper_drop) begin
                    coins_d = coins_q - 2'd1;
                    if (coins_q == 2'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d  = EJECT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(COIN_TO - 1);
                    end
                end else if (tmr_expire_c) begin
                    state_d = FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = IDLE;
                    coins_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d    = (state_d == IDLE);
        busy_d         = (state_d != IDLE);
        sol_cola_d     = (state_d == DISP) && (item_d == ITEM_COLA);
        sol_pepsi_d    = (state_d == DISP) && (item_d == ITEM_PEPSI);
        hopper_pulse_d = (state_d == EJECT);
        done_d         = (state_d == DONE);
        vend_ok_d      = (state_d == DONE) && disp_d;
        fault_d        = (state_d == FAULT);
    end

`ifdef VM_AUDIT_EN
    logic disp_evt_c;
    logic drop_evt_c;

    assign disp_evt_c = (state_q == IDLE) && (state_d == DISP);
    assign drop_evt_c = (state_q == WAIT) && hopper_drop;

    // Saturating audit counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sales_cola  <= '0;
            sales_pepsi <= '0;
            coins_paid  <= '0;
        end else begin
            if (disp_evt_c && (item_d == ITEM_COLA)) begin
                sales_cola <= sat_inc(sales_cola);
            end
            if (disp_evt_c && (item_d == ITEM_PEPSI)) begin
                sales_pepsi <= sat_inc(sales_pepsi);
            end
            if (drop_evt_c) begin
                coins_paid <= sat_inc(coins_paid);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vm_dispense_seq.sv
// Directed self-checking bench for vm_dispense_seq (PULSE_CYC=4, COIN_TO=16, INV_INIT=8).
module tb_vm_dispense_seq;

    localparam int unsigned PULSE_CYC = 4;
    localparam int unsigned COIN_TO   = 16;
    localparam int unsigned INV_W     = 4;
    localparam int unsigned INV_INIT  = 8;

    localparam logic [1:0] COLA  = 2'b01;
    localparam logic [1:0] PEPSI = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_refund;
    logic [1:0] req_item, req_change;
    logic       sol_cola, sol_pepsi, hopper_pulse, hopper_drop;
    logic       restock, fault_clr;
    logic [1:0] sold_out;
    logic       busy, done, vend_ok, fault;
`ifdef VM_AUDIT_EN
    logic [15:0] sales_cola, sales_pepsi, coins_paid;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vm_dispense_seq #(
        .PULSE_CYC (PULSE_CYC),
        .COIN_TO   (COIN_TO),
        .INV_W     (INV_W),
        .INV_INIT  (INV_INIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_item     (req_item),
        .req_change   (req_change),
        .req_refund   (req_refund),
        .sol_cola     (sol_cola),
        .sol_pepsi    (sol_pepsi),
        .hopper_pulse (hopper_pulse),
        .hopper_drop  (hopper_drop),
        .restock      (restock),
        .fault_clr    (fault_clr),
        .sold_out     (sold_out),
        .busy         (busy),
        .done         (done),
        .vend_ok      (vend_ok),
        .fault        (fault)
`ifdef VM_AUDIT_EN
        ,
        .sales_cola   (sales_cola),
        .sales_pepsi  (sales_pepsi),
        .coins_paid   (coins_paid)
`endif
    );

    task automatic do_reset();
        reset = 1'b0; req_valid = 1'b0; req_item = 2'b00; req_change = 2'd0;
        req_refund = 1'b0; hopper_drop = 1'b0; restock = 1'b0; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Offer one request for a single cycle; returns at the negedge of cycle 1.
    task automatic offer(input logic [1:0] item, input logic [1:0] chg,
                         input logic rf, input logic rs);
        req_valid = 1'b1; req_item = item; req_change = chg; req_refund = rf; restock = rs;
        @(negedge clk);
        req_valid = 1'b0; req_item = 2'b00; req_change = 2'd0; req_refund = 1'b0; restock = 1'b0;
    endtask

    // Observe one transaction, answering each pulse with a drop dly cycles later.
    task automatic run_txn(input int maxc, input int dly, input bit spur,
                           output int sc, output int sp, output int hp, output int dn,
                           output int dcyc, output bit vok, output int pcyc, output int fcyc);
        int drop_at;
        drop_at = -1; sc = 0; sp = 0; hp = 0; dn = 0; dcyc = -1; vok = 1'b0; pcyc = -1; fcyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            if (sol_cola)  sc++;
            if (sol_pepsi) sp++;
            if (hopper_pulse) begin
                hp++;
                pcyc = c;
                if (dly >= 0) drop_at = c + dly;
            end
            hopper_drop = (c == drop_at) || (spur && (c == 2));
            if (done) begin
                dn++;
                dcyc = c;
                vok  = vend_ok;
            end
            if (fault) begin
                fcyc = c;
                break;
            end
            @(negedge clk);
            if (dn != 0) break;
        end
        hopper_drop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_item = 2'b00; req_change = 2'd0;
        req_refund = 1'b0; hopper_drop = 1'b0; restock = 1'b0; fault_clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, busy, sol_cola, sol_pepsi, hopper_pulse, done, vend_ok, fault, sold_out} !== 10'b10_0000_0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 1000000000",
                     {req_ready, busy, sol_cola, sol_pepsi, hopper_pulse, done, vend_ok, fault, sold_out});
        end
        checks++;
        if (dut.inv_cola_q !== 4'd8 || dut.inv_pepsi_q !== 4'd8) begin
            failures++;
            $display("FAIL reset_inventory: got cola=%0d pepsi=%0d expected 8/8", dut.inv_cola_q, dut.inv_pepsi_q);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cola_change();
        int sc, sp, hp, dn, dcyc, pcyc, fcyc;
        bit vok;
        do_reset();
        offer(COLA, 2'd1, 1'b0, 1'b0);
        run_txn(40, 2, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (sc !== 4 || sp !== 0) begin
            failures++;
            $display("FAIL cola_solenoid: got cola=%0d pepsi=%0d cycles expected 4/0", sc, sp);
        end
        checks++;
        if (hp !== 1 || pcyc !== 5) begin
            failures++;
            $display("FAIL cola_pulse: got count=%0d at cycle %0d expected 1 at 5", hp, pcyc);
        end
        checks++;
        if (dn !== 1 || dcyc !== 8 || vok !== 1'b1) begin
            failures++;
            $display("FAIL cola_done: got done=%0d cycle=%0d vend_ok=%0d expected 1/8/1", dn, dcyc, vok);
        end
        checks++;
        if (dut.inv_cola_q !== 4'd7 || dut.inv_pepsi_q !== 4'd8 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL cola_inventory: got cola=%0d pepsi=%0d ready=%0d expected 7/8/1",
                     dut.inv_cola_q, dut.inv_pepsi_q, req_ready);
        end
    endtask

    task automatic test_refund();
        int sc, sp, hp, dn, dcyc, pcyc, fcyc;
        bit vok;
        do_reset();
        offer(PEPSI, 2'd2, 1'b1, 1'b0);
        run_txn(40, 2, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (sc !== 0 || sp !== 0 || hp !== 2) begin
            failures++;
            $display("FAIL refund_actuators: got sol=%0d/%0d pulses=%0d expected 0/0/2", sc, sp, hp);
        end
        checks++;
        if (dn !== 1 || dcyc !== 7 || vok !== 1'b0) begin
            failures++;
            $display("FAIL refund_done: got done=%0d cycle=%0d vend_ok=%0d expected 1/7/0", dn, dcyc, vok);
        end
        checks++;
        if (dut.inv_cola_q !== 4'd8 || dut.inv_pepsi_q !== 4'd8) begin
            failures++;
            $display("FAIL refund_inventory: got %0d/%0d expected 8/8", dut.inv_cola_q, dut.inv_pepsi_q);
        end
    endtask

    task automatic test_sold_out();
        int sc, sp, hp, dn, dcyc, pcyc, fcyc;
        bit vok;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            offer(PEPSI, 2'd0, 1'b0, 1'b0);
            run_txn(20, -1, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
            checks++;
            if (sp !== 4 || dn !== 1 || dcyc !== 5 || vok !== 1'b1) begin
                failures++;
                $display("FAIL pepsi_vend_%0d: got sol=%0d done=%0d cycle=%0d ok=%0d expected 4/1/5/1",
                         i, sp, dn, dcyc, vok);
            end
        end
        checks++;
        if (sold_out !== 2'b10 || dut.inv_pepsi_q !== 4'd0) begin
            failures++;
            $display("FAIL pepsi_empty: got sold_out=%b inv=%0d expected 10/0", sold_out, dut.inv_pepsi_q);
        end
        offer(PEPSI, 2'd0, 1'b0, 1'b0);
        run_txn(20, -1, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (sp !== 0 || dn !== 1 || dcyc !== 1 || vok !== 1'b0) begin
            failures++;
            $display("FAIL pepsi_ninth: got sol=%0d done=%0d cycle=%0d ok=%0d expected 0/1/1/0", sp, dn, dcyc, vok);
        end
        // Restock coincident with a pepsi request: decision still sees the empty count.
        offer(PEPSI, 2'd0, 1'b0, 1'b1);
        run_txn(20, -1, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (sp !== 0 || dn !== 1 || vok !== 1'b0) begin
            failures++;
            $display("FAIL restock_same_cycle: got sol=%0d done=%0d ok=%0d expected 0/1/0", sp, dn, vok);
        end
        checks++;
        if (sold_out !== 2'b00 || dut.inv_pepsi_q !== 4'd8 || dut.inv_cola_q !== 4'd8) begin
            failures++;
            $display("FAIL restock_result: got sold_out=%b inv=%0d/%0d expected 00/8/8",
                     sold_out, dut.inv_cola_q, dut.inv_pepsi_q);
        end
        offer(PEPSI, 2'd0, 1'b0, 1'b0);
        run_txn(20, -1, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (sp !== 4 || vok !== 1'b1 || dut.inv_pepsi_q !== 4'd7) begin
            failures++;
            $display("FAIL pepsi_after_restock: got sol=%0d ok=%0d inv=%0d expected 4/1/7", sp, vok, dut.inv_pepsi_q);
        end
    endtask

    task automatic test_fault();
        int sc, sp, hp, dn, dcyc, pcyc, fcyc;
        bit vok;
        do_reset();
        offer(COLA, 2'd1, 1'b0, 1'b0);
        run_txn(40, -1, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (pcyc !== 5 || fcyc !== 21) begin
            failures++;
            $display("FAIL fault_timing: got pulse=%0d fault=%0d expected 5/21", pcyc, fcyc);
        end
        checks++;
        if (fault !== 1'b1 || req_ready !== 1'b0 || dn !== 0 || hp !== 1) begin
            failures++;
            $display("FAIL fault_state: got fault=%0d ready=%0d done=%0d pulses=%0d expected 1/0/0/1",
                     fault, req_ready, dn, hp);
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || dut.inv_cola_q !== 4'd7) begin
            failures++;
            $display("FAIL fault_clear: got fault=%0d ready=%0d busy=%0d inv=%0d expected 0/1/0/7",
                     fault, req_ready, busy, dut.inv_cola_q);
        end
    endtask

    task automatic test_reset_mid();
        int sc, sp, hp, dn, dcyc, pcyc, fcyc;
        bit vok;
        do_reset();
        offer(COLA, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (sol_cola !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_before_reset: got sol=%0d busy=%0d ready=%0d expected 1/1/0", sol_cola, busy, req_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (sol_cola !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || dut.inv_cola_q !== 4'd8) begin
            failures++;
            $display("FAIL mid_reset: got sol=%0d busy=%0d ready=%0d inv=%0d expected 0/0/1/8",
                     sol_cola, busy, req_ready, dut.inv_cola_q);
        end
        @(negedge clk);
        reset = 1'b1;
        run_txn(10, -1, 1'b0, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (dn !== 0 || sc !== 0) begin
            failures++;
            $display("FAIL mid_abandon: got done=%0d sol=%0d expected 0/0", dn, sc);
        end
    endtask

    task automatic test_spurious_drop();
        int sc, sp, hp, dn, dcyc, pcyc, fcyc;
        bit vok;
        do_reset();
        offer(COLA, 2'd3, 1'b0, 1'b0);
        run_txn(60, 2, 1'b1, sc, sp, hp, dn, dcyc, vok, pcyc, fcyc);
        checks++;
        if (hp !== 3 || sc !== 4) begin
            failures++;
            $display("FAIL spur_pulses: got pulses=%0d sol=%0d expected 3/4", hp, sc);
        end
        checks++;
        if (dn !== 1 || dcyc !== 14 || vok !== 1'b1) begin
            failures++;
            $display("FAIL spur_done: got done=%0d cycle=%0d ok=%0d expected 1/14/1", dn, dcyc, vok);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cola_change();
        test_refund();
        test_sold_out();
        test_fault();
        test_reset_mid();
        test_spurious_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vm_dispense_seq.md
Name: vm_dispense_seq

Overview:
Back-end sequencer for the two-item vending machine. It accepts one vend transaction from the vending FSM over a valid/ready handshake and times the item solenoid. It then ejects change one 5-unit coin at a time through the hopper, with drop-sensor confirmation and a timeout. It also tracks per-item inventory and flags sold-out items back to the front-end FSM.

Parameters:
PULSE_CYC, 4, solenoid on-time in clk cycles (>=1)
COIN_TO, 16, max cycles to wait for hopper_drop after a hopper_pulse
INV_W, 4, inventory counter width
INV_INIT, 8, inventory loaded at reset/restock (< 2**INV_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  transaction offered
req_ready  out  1  sequencer can accept
req_item  in  2  01=cola, 10=pepsi, 00/11=no item
req_change  in  2  change in 5-unit coins: 0..3
req_refund  in  1  cancel: return change only, no dispense
sol_cola  out  1  cola solenoid
sol_pepsi  out  1  pepsi solenoid
hopper_pulse  out  1  one-cycle eject-one-coin command
hopper_drop  in  1  coin-fell sensor, one-cycle pulse
restock  in  1  reload both inventories
fault_clr  in  1  clear hopper fault
sold_out  out  2  [0]=cola empty, [1]=pepsi empty
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-transaction pulse
vend_ok  out  1  valid with done: item was dispensed
fault  out  1  hopper timeout, sticky

Behaviour:
- Reset (async, reset=0): state=IDLE; all outputs 0 except req_ready=1; inventories=INV_INIT; solenoids drop immediately.
- req_ready = (state==IDLE) && !fault. Accept on a rising edge with req_valid && req_ready. At accept, latch item, coins=req_change, refund.
- Dispense condition: item legal && !refund && !sold_out[item] (registered value).
  - Met: go to DISP and decrement that inventory at the accept edge.
  - Not met: go straight to the change path (coins>0 ? EJECT : DONE) with vend_ok=0.
- DISP: the matching solenoid is high for exactly PULSE_CYC cycles, then coins>0 ? EJECT : DONE.
- EJECT: hopper_pulse=1 for one cycle, then WAIT with the timer loaded to COIN_TO.
- WAIT:
  - hopper_drop: coins-1. If that reaches 0, go to DONE; otherwise go to EJECT.
  - Timer expires with no drop: go to FAULT.
  - hopper_drop in any other state is ignored.
- DONE: done=1 and vend_ok for one cycle, then IDLE.
- FAULT: fault=1, req_ready=0, no outputs driven. fault_clr goes to IDLE and clears fault; remaining coins are discarded.
- Latency, dispense without change: accept at edge 0, solenoid high in cycles 1..PULSE_CYC, done in cycle PULSE_CYC+1.
- restock is honoured only in IDLE and ignored elsewhere.
  - restock in the same cycle as an accept: the sold-out decision uses the pre-restock count.
  - Result: inventory = INV_INIT, minus 1 if the request dispenses.
- sold_out[i] = (inv_i == 0), combinational from the registers. Inventory never goes below 0.
- Reset mid-transaction abandons it: no done, and coins are lost.

Optional Feature:
VM_AUDIT_EN
- Defined: adds outputs sales_cola[15:0], sales_pepsi[15:0] and coins_paid[15:0].
  - Counters increment on each dispense and on each accepted hopper_drop, and saturate at 16'hFFFF.
  - Counters are cleared only by reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package vm_pkg:
  - item codes ITEM_NONE/ITEM_COLA/ITEM_PEPSI
  - coin unit constant COIN_UNIT=5
  - state enum IDLE/DISP/EJECT/WAIT/DONE/FAULT
- One sub-module, vm_timer: a loadable down-counter with an expire flag. It is shared by the solenoid pulse and the coin timeout, which are never active together.

Test Plan:
All scenarios use PULSE_CYC=4, COIN_TO=16, INV_INIT=8.
- Reset, then cola with req_change=1; drop 2 cycles after the pulse -> sol_cola high 4 cycles, one hopper_pulse, done with vend_ok=1, cola inventory 7.
- req_refund=1, req_item=10, req_change=2 -> no solenoid; two hopper_pulses, each following a drop; done with vend_ok=0; inventories stay 8.
- 8 pepsi vends -> sold_out=2'b10. 9th pepsi with change 0 -> no solenoid, done vend_ok=0. Then restock in IDLE -> sold_out=00.
- Cola with change 1, hopper_drop withheld -> fault=1 and req_ready=0 sixteen cycles after the pulse. fault_clr -> IDLE, req_ready=1.
- Reset driven low in the 2nd solenoid cycle -> sol_cola=0 immediately, busy=0, no done, inventories 8.
- Change 3 with a spurious hopper_drop during DISP -> drop ignored; exactly 3 hopper_pulses, done after the 3rd drop.
